bar_enc: RTL and testbench
==========================

# bar_enc

Serial encoder for the 21-segment LED bar. It captures a 21-bit bar pattern and scans it one segment per clock. It reports the lowest lit index as N1 and the highest lit index as N2, plus the running scan index as a sawtooth count. Its outputs are the same N1/N2/sawtooth quantities the LED decoder consumes, so a bar pattern fed through this block and then the decoder reproduces the lit window. It sits between a bar-pattern source (sensor/comparator bank or test register) and the display path.

## Interface
- WIDTH, 21, number of bar segments; scan length in cycles
- DW, 8, width of index outputs; must satisfy 2^DW > WIDTH
- clc_i  input  1  system clock, all logic on rising edge
- rst_i  input  1  reset, synchronous, active-low
- start_i  input  1  request a scan; sampled only in IDLE
- bar_i  input  WIDTH  bar pattern, bit k = segment k; captured on the accepting edge
- busy_o  output  1  high while state is SCAN
- valid_o  output  1  one-cycle pulse: N1/N2/flags updated
- N1_data_o  output  DW  lowest lit index of last completed scan
- N2_data_o  output  DW  highest lit index of last completed scan
- empty_o  output  1  last scan found no lit segment
- gap_o  output  1  last scan found a non-contiguous pattern
- sawtooth_cntr_o  output  DW  current scan index in SCAN, 0 otherwise

## Operation
- States: IDLE, SCAN. There is no separate DONE state.
- IDLE, start_i=1 at an edge:
  - shadow <= bar_i; idx <= 0; found <= 0; ended <= 0; gap_acc <= 0.
  - Go to SCAN.
- SCAN, each edge, processes bit b = shadow[idx]:
  - If b=1 and found=0: n1_acc <= idx; found <= 1.
  - If b=1: n2_acc <= idx.
  - If b=1 and ended=1: gap_acc <= 1.
  - If b=0 and found=1: ended <= 1.
  - If idx == WIDTH-1: commit results, pulse valid_o, go to IDLE. Otherwise idx <= idx+1.
- Commit rules. The commit uses the values including the final bit.
  - Not empty: N1_data_o = first lit index, N2_data_o = last lit index, empty_o = 0, gap_o = final gap flag.
  - Empty: N1_data_o = 0, N2_data_o = 0, empty_o = 1, gap_o = 0.
- Invariant: when not empty, N2_data_o >= N1_data_o, so N2-N1 never underflows in DW bits.
- Width rules:
  - Indices are zero-extended from ceil(log2(WIDTH)) bits to DW.
  - idx never exceeds WIDTH-1; no wrap occurs.
- Outputs N1/N2/empty/gap hold between commits.
- sawtooth_cntr_o equals idx while busy_o=1 and is forced to 0 in IDLE.
- start_i during SCAN is ignored; it is not queued.
- bar_i changes during SCAN have no effect, because the shadow copy is used.

## Timing
- Reset (rst_i=0 at an edge): state IDLE; all outputs 0; shadow, idx and all flags cleared.
- Reset mid-scan: the scan is aborted, no valid_o is issued, and outputs are forced to 0.
- Start accepted at edge E0: busy_o=1 from E0 through E(WIDTH), i.e. WIDTH cycles.
- Commit occurs at edge E(WIDTH). valid_o is high for exactly the one cycle after E(WIDTH). busy_o is 0 in that same cycle.
- Latency from start acceptance to valid is WIDTH cycles (21 by default).
- Back-to-back: start_i=1 in the valid_o cycle is accepted at the next edge. Sustained throughput is one result per WIDTH+1 cycles.
- sawtooth_cntr_o shows 0,1,…,WIDTH-1 during cycles E0..E(WIDTH-1), then returns to 0.

## Test plan
- Reset: hold rst_i=0 for 3 cycles with start_i=1 and bar_i=0x1FFFFF -> all outputs 0, busy_o never asserts.
- Contiguous window: bar_i=0x000F0, start pulse -> valid_o exactly 21 cycles later with N1=4, N2=7, empty_o=0, gap_o=0. Feeding N1/N2 to the decoder reproduces 0x000F0.
- Edges and full bar:
  - bar_i=0x100001 -> N1=0, N2=20, gap_o=1.
  - bar_i=0x1FFFFF -> N1=0, N2=20, gap_o=0.
  - bar_i=0x100000 -> N1=20, N2=20.
- Empty, then stability: bar_i=0 -> empty_o=1, N1=N2=0. bar_i toggling randomly during a scan of 0x00C00 -> N1=10, N2=11 regardless of the toggling.
- Handshake:
  - start_i held high continuously -> valid_o pulses every 22 cycles; sawtooth_cntr_o ramps 0..20 then 0.
  - Extra start pulses mid-scan -> no change in timing.
- Reset mid-scan: assert rst_i=0 at scan index 10 -> no valid_o; outputs 0; the next start scans normally.

Source files
------------

// File: rtl/bar_enc_if.sv
// Request/result bundle between a bar-pattern source and the bar encoder.
interface bar_enc_if #(
  parameter int WIDTH = 21,
  parameter int DW    = 8
);
  logic             start_i;
  logic [WIDTH-1:0] bar_i;
  logic             busy_o;
  logic             valid_o;
  logic [DW-1:0]    N1_data_o;
  logic [DW-1:0]    N2_data_o;
  logic             empty_o;
  logic             gap_o;
  logic [DW-1:0]    sawtooth_cntr_o;

  modport slave (
    input  start_i, bar_i,
    output busy_o, valid_o, N1_data_o, N2_data_o, empty_o, gap_o, sawtooth_cntr_o
  );

  modport master (
    output start_i, bar_i,
    input  busy_o, valid_o, N1_data_o, N2_data_o, empty_o, gap_o, sawtooth_cntr_o
  );
endinterface

// File: rtl/bar_enc.sv
// Serial bar encoder: scans a captured bar pattern one segment per clock and
// reports the lowest/highest lit index, an empty flag and a gap flag.
module bar_enc #(
  parameter int WIDTH = 21,
  parameter int DW    = 8
) (
  input  logic    clc_i,
  input  logic    rst_i,
  bar_enc_if.slave bus
);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             found_q, found_d;
  logic             ended_q, ended_d;
  logic             gap_acc_q, gap_acc_d;
  logic [IW-1:0]    n1_acc_q, n1_acc_d;
  logic [IW-1:0]    n2_acc_q, n2_acc_d;
  logic [IW-1:0]    n1_q, n1_d;
  logic [IW-1:0]    n2_q, n2_d;
  logic             empty_q, empty_d;
  logic             gap_q, gap_d;
  logic             valid_q, valid_d;
  logic             seg_b;

  assign seg_b = shadow_q[idx_q];

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    idx_d     = idx_q;
    found_d   = found_q;
    ended_d   = ended_q;
    gap_acc_d = gap_acc_q;
    n1_acc_d  = n1_acc_q;
    n2_acc_d  = n2_acc_q;
    n1_d      = n1_q;
    n2_d      = n2_q;
    empty_d   = empty_q;
    gap_d     = gap_q;
    valid_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          shadow_d  = bus.bar_i;
          idx_d     = '0;
          found_d   = 1'b0;
          ended_d   = 1'b0;
          gap_acc_d = 1'b0;
          n1_acc_d  = '0;
          n2_acc_d  = '0;
          state_d   = SCAN;
        end
      end
      SCAN: begin
        if (seg_b && !found_q) begin
          n1_acc_d = idx_q;
          found_d  = 1'b1;
        end
        if (seg_b) n2_acc_d = idx_q;
        if (seg_b && ended_q) gap_acc_d = 1'b1;
        if (!seg_b && found_q) ended_d = 1'b1;
        // Commit sees the accumulators already updated with the final segment.
        if (idx_q == LAST) begin
          n1_d    = found_d ? n1_acc_d : '0;
          n2_d    = found_d ? n2_acc_d : '0;
          empty_d = !found_d;
          gap_d   = found_d & gap_acc_d;
          valid_d = 1'b1;
          state_d = IDLE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clc_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      shadow_q  <= '0;
      idx_q     <= '0;
      found_q   <= 1'b0;
      ended_q   <= 1'b0;
      gap_acc_q <= 1'b0;
      n1_acc_q  <= '0;
      n2_acc_q  <= '0;
      n1_q      <= '0;
      n2_q      <= '0;
      empty_q   <= 1'b0;
      gap_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      idx_q     <= idx_d;
      found_q   <= found_d;
      ended_q   <= ended_d;
      gap_acc_q <= gap_acc_d;
      n1_acc_q  <= n1_acc_d;
      n2_acc_q  <= n2_acc_d;
      n1_q      <= n1_d;
      n2_q      <= n2_d;
      empty_q   <= empty_d;
      gap_q     <= gap_d;
      valid_q   <= valid_d;
    end
  end

  assign bus.busy_o          = (state_q == SCAN);
  assign bus.valid_o         = valid_q;
  assign bus.N1_data_o       = DW'(n1_q);
  assign bus.N2_data_o       = DW'(n2_q);
  assign bus.empty_o         = empty_q;
  assign bus.gap_o           = gap_q;
  assign bus.sawtooth_cntr_o = (state_q == SCAN) ? DW'(idx_q) : '0;
endmodule

// File: tb/tb_bar_enc.sv
// Randomized bench for bar_enc against a set-based model of the bar pattern.
module tb_bar_enc;
  localparam int WIDTH = 21;
  localparam int DW    = 8;

  logic clc_i = 1'b0;
  logic rst_i = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  bar_enc_if #(.WIDTH(WIDTH), .DW(DW)) bus ();

  bar_enc #(.WIDTH(WIDTH), .DW(DW)) u_dut (
    .clc_i (clc_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  always #5 clc_i = ~clc_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Reference: lit set -> min, max, and contiguity by population count.
  task automatic model(input logic [WIDTH-1:0] p, output int n1, output int n2,
                       output bit emp, output bit gp);
    int lo = -1, hi = -1, cnt = 0;
    for (int i = 0; i < WIDTH; i++)
      if (p[i]) begin
        if (lo < 0) lo = i;
        hi = i;
        cnt++;
      end
    if (lo < 0) begin
      n1 = 0; n2 = 0; emp = 1'b1; gp = 1'b0;
    end else begin
      n1 = lo; n2 = hi; emp = 1'b0; gp = (cnt != hi - lo + 1);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy_o), 32'd0);
    chk({tag, "_valid"}, 32'(bus.valid_o), 32'd0);
    chk({tag, "_n1"}, 32'(bus.N1_data_o), 32'd0);
    chk({tag, "_n2"}, 32'(bus.N2_data_o), 32'd0);
    chk({tag, "_empty"}, 32'(bus.empty_o), 32'd0);
    chk({tag, "_gap"}, 32'(bus.gap_o), 32'd0);
    chk({tag, "_saw"}, 32'(bus.sawtooth_cntr_o), 32'd0);
  endtask

  // Caller guarantees the DUT is idle at the next edge.
  task automatic do_scan(input logic [WIDTH-1:0] p, input bit toggle, input bit extra);
    int n1, n2;
    bit e, g;
    logic [WIDTH-1:0] win;
    model(p, n1, n2, e, g);
    @(negedge clc_i);
    bus.start_i = 1'b1;
    bus.bar_i   = p;
    @(negedge clc_i);
    bus.start_i = 1'b0;
    for (int k = 0; k < WIDTH; k++) begin
      chk("scan_busy", 32'(bus.busy_o), 32'd1);
      chk("scan_saw", 32'(bus.sawtooth_cntr_o), 32'(k));
      chk("scan_valid_early", 32'(bus.valid_o), 32'd0);
      if (toggle) bus.bar_i = WIDTH'($urandom);
      if (extra) bus.start_i = 1'($urandom);
      @(negedge clc_i);
    end
    bus.start_i = 1'b0;
    chk("done_valid", 32'(bus.valid_o), 32'd1);
    chk("done_busy", 32'(bus.busy_o), 32'd0);
    chk("done_saw", 32'(bus.sawtooth_cntr_o), 32'd0);
    chk("n1", 32'(bus.N1_data_o), 32'(n1));
    chk("n2", 32'(bus.N2_data_o), 32'(n2));
    chk("empty", 32'(bus.empty_o), 32'(e));
    chk("gap", 32'(bus.gap_o), 32'(g));
    if (!e && !g) begin
      win = '0;
      for (int i = 0; i < WIDTH; i++)
        if (i >= int'(bus.N1_data_o) && i <= int'(bus.N2_data_o)) win[i] = 1'b1;
      chk("window", 32'(win), 32'(p));
    end
    @(negedge clc_i);
    chk("valid_pulse", 32'(bus.valid_o), 32'd0);
    chk("hold_n1", 32'(bus.N1_data_o), 32'(n1));
  endtask

  initial begin
    logic [WIDTH-1:0] p;
    int n1, n2, nvalid, lo, len;
    bit e, g;

    // Reset held with start high and a full bar.
    bus.start_i = 1'b1;
    bus.bar_i   = '1;
    rst_i       = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clc_i);
      chk_idle_zero("reset");
    end
    bus.start_i = 1'b0;
    rst_i       = 1'b1;
    @(negedge clc_i);

    do_scan(21'h000F0, 1'b0, 1'b0);
    do_scan(21'h100001, 1'b0, 1'b0);
    do_scan(21'h1FFFFF, 1'b0, 1'b0);
    do_scan(21'h100000, 1'b0, 1'b0);
    do_scan(21'h000001, 1'b0, 1'b0);
    do_scan(21'h000000, 1'b0, 1'b0);
    do_scan(21'h00C00, 1'b1, 1'b0);
    do_scan(21'h0A5A5, 1'b0, 1'b1);

    // Start held high: one result per WIDTH+1 cycles.
    p = 21'h03F00;
    model(p, n1, n2, e, g);
    @(negedge clc_i);
    bus.start_i = 1'b1;
    bus.bar_i   = p;
    @(negedge clc_i);
    for (int k = 0; k < 3 * (WIDTH + 1); k++) begin
      if (k % (WIDTH + 1) < WIDTH) begin
        chk("cont_busy", 32'(bus.busy_o), 32'd1);
        chk("cont_saw", 32'(bus.sawtooth_cntr_o), 32'(k % (WIDTH + 1)));
        chk("cont_valid", 32'(bus.valid_o), 32'd0);
      end else begin
        chk("cont_valid", 32'(bus.valid_o), 32'd1);
        chk("cont_busy", 32'(bus.busy_o), 32'd0);
        chk("cont_n1", 32'(bus.N1_data_o), 32'(n1));
        chk("cont_n2", 32'(bus.N2_data_o), 32'(n2));
      end
      @(negedge clc_i);
    end
    bus.start_i = 1'b0;
    repeat (WIDTH + 2) @(negedge clc_i);
    chk("cont_drained", 32'(bus.busy_o), 32'd0);

    // Reset at scan index 10 after a non-zero result is on the outputs.
    @(negedge clc_i);
    bus.start_i = 1'b1;
    bus.bar_i   = 21'h00F00;
    @(negedge clc_i);
    bus.start_i = 1'b0;
    for (int k = 0; k < 10; k++) @(negedge clc_i);
    chk("mid_saw", 32'(bus.sawtooth_cntr_o), 32'd10);
    rst_i = 1'b0;
    @(negedge clc_i);
    chk_idle_zero("midrst");
    rst_i  = 1'b1;
    nvalid = 0;
    for (int k = 0; k < WIDTH + 4; k++) begin
      @(negedge clc_i);
      if (bus.valid_o || bus.busy_o) nvalid++;
    end
    chk("midrst_quiet", 32'(nvalid), 32'd0);
    do_scan(21'h0F000, 1'b0, 1'b0);

    // Random patterns, half of them contiguous windows.
    for (int t = 0; t < 24; t++) begin
      if (t % 2 == 0) begin
        p = WIDTH'($urandom);
      end else begin
        lo  = $urandom_range(0, WIDTH - 1);
        len = $urandom_range(1, WIDTH - lo);
        p   = '0;
        for (int i = lo; i < lo + len; i++) p[i] = 1'b1;
      end
      do_scan(p, 1'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
